sc_randomgen: RTL and testbench
===============================

SC_RANDOMGEN -- requirements
Module: SC_RANDOMGEN

Interface
REQ-001 The block SHALL have parameter RANDOMGEN_DATAWIDTH, default 8, giving the data bus width; only 8 is supported.
REQ-002 The block SHALL have parameter RANDOMGEN_TAPS, default 8'hB8, giving the Galois LFSR feedback mask (x^8+x^6+x^5+x^4+1).
REQ-003 The block SHALL have parameter RANDOMGEN_SEED, default 8'hA5, giving the nonzero reset and default seed.
REQ-004 The block SHALL have parameter RANDOMGEN_PRESCALE, default 4, giving the clock cycles per LFSR step; legal values are 1 and above.
REQ-005 The block SHALL have SC_RANDOMGEN_CLOCK_50, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have SC_RANDOMGEN_RESET_InHigh, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have SC_RANDOMGEN_run_InLow, input, 1 bit: level run request, active-low.
REQ-008 The block SHALL have SC_RANDOMGEN_seed_InLow, input, 1 bit: seed-load request, active-low.
REQ-009 The block SHALL have SC_RANDOMGEN_seed_InBUS, input, DATAWIDTH bits: seed value.
REQ-010 The block SHALL have SC_RANDOMGEN_data_OutBUS, output, DATAWIDTH bits: registered random value, fed to the general register's data input.
REQ-011 The block SHALL have SC_RANDOMGEN_valid_Out, output, 1 bit: registered pulse, high for the cycle in which data_OutBUS holds a newly produced value.
REQ-012 The block SHALL have SC_RANDOMGEN_busy_Out, output, 1 bit: registered, high while the block is in state RUN.

Function
REQ-013 The block SHALL implement the states IDLE, RUN and LOAD, held in a registered state variable.
REQ-014 The block SHALL make a seed request (seed_InLow=0) take priority over run in every state; the next state is LOAD.
REQ-015 On an edge in which a seed request is sampled, the block SHALL load data=seed_InBUS, or data=RANDOMGEN_SEED if seed_InBUS==0, clear the prescaler to 0 and set valid=1 for the next cycle.
REQ-016 The block SHALL repeat the load on every edge while seed_InLow is held low, giving a valid pulse per load.
REQ-017 The block SHALL take these exits from LOAD: if seed is still low, stay in LOAD; else if run_InLow=0, go to RUN; else go to IDLE. No LFSR step occurs in LOAD.
REQ-018 The block SHALL go from IDLE to RUN when run_InLow=0 is sampled; the prescaler is 0 on entry.
REQ-019 In RUN, the block SHALL count the prescaler 0..PRESCALE-1; on the edge where prescaler==PRESCALE-1 it steps the LFSR, wraps the prescaler to 0 and sets valid=1 for the next cycle.
REQ-020 The LFSR step SHALL be: if data[0]==1 then data=(data>>1)^TAPS, else data=data>>1.
REQ-021 The block SHALL go from RUN to IDLE when run_InLow=1 is sampled, with no step on that edge and the prescaler cleared; a partial count is discarded.
REQ-022 First-step latency SHALL be PRESCALE edges after the edge that entered RUN; with PRESCALE=1 the block steps on every edge in RUN.
REQ-023 The block SHALL drive valid_Out low in every cycle not selected by REQ-015 or REQ-019, and SHALL hold data_OutBUS unchanged in IDLE.
REQ-024 data_OutBUS SHALL never be 0x00, because zero seeds are substituted and the Galois LFSR cannot reach zero from a nonzero state.
REQ-025 busy_Out SHALL equal (state==RUN), registered with the state.

Reset
REQ-026 When RESET_InHigh=1 on an edge, the block SHALL set state=IDLE, prescaler=0, data_OutBUS=RANDOMGEN_SEED, valid_Out=0 and busy_Out=0.
REQ-027 Reset SHALL override a simultaneous seed or run request, and SHALL abort an in-progress RUN or LOAD with no valid pulse.
REQ-028 After reset is released, the first edge SHALL be handled as from IDLE.

Verification
REQ-029 Reset asserted 2 cycles -> data=0xA5, valid=0, busy=0.
REQ-030 Defaults, run_InLow held 0 from the first edge after reset -> busy=1; data 0xA5 -> 0xEA after 4 edges, -> 0x75 after 8, -> 0x82 after 12; valid is a single-cycle pulse aligned with each new value.
REQ-031 In IDLE, seed_InLow=0 for 1 cycle with seed 0x01 -> data=0x01 with one valid pulse; then run -> 0xB8, 0x5C, 0x2E, 0x17, 0xB3, each 4 cycles apart.
REQ-032 seed_InBUS=0x00 loaded -> data=0xA5, never 0x00.
REQ-033 run deasserted after 2 counts, then reasserted -> no step and busy=0 while deasserted; the next step needs a full 4 edges after re-entry.
REQ-034 Reset asserted together with seed=0x33 during RUN -> data=0xA5, IDLE, valid=0.
REQ-035 Free run for 255 steps from 0xA5 -> returns to 0xA5, all 255 values distinct and nonzero.

Source files
------------

// File: rtl/sc_randomgen.sv
// sc_randomgen: free-running 8-bit Galois LFSR random source.
// A seed request loads a (nonzero) seed. A level run request steps the LFSR
// once every RANDOMGEN_PRESCALE clock edges. Each newly produced value is
// flagged by a one-cycle valid pulse.
//
// Handshake: valid_Out is a registered, single-cycle strobe. It is high for
// exactly the cycle in which data_OutBUS holds a value that was just loaded
// or stepped. There is no back-pressure, so a consumer must accept on valid.
module sc_randomgen #(
  parameter int                               RANDOMGEN_DATAWIDTH = 8,
  parameter logic [RANDOMGEN_DATAWIDTH-1:0]   RANDOMGEN_TAPS      = 8'hB8,
  parameter logic [RANDOMGEN_DATAWIDTH-1:0]   RANDOMGEN_SEED      = 8'hA5,
  parameter int                               RANDOMGEN_PRESCALE  = 4
) (
  input  logic                           SC_RANDOMGEN_CLOCK_50,
  input  logic                           SC_RANDOMGEN_RESET_InHigh,
  input  logic                           SC_RANDOMGEN_run_InLow,
  input  logic                           SC_RANDOMGEN_seed_InLow,
  input  logic [RANDOMGEN_DATAWIDTH-1:0] SC_RANDOMGEN_seed_InBUS,
  output logic [RANDOMGEN_DATAWIDTH-1:0] SC_RANDOMGEN_data_OutBUS,
  output logic                           SC_RANDOMGEN_valid_Out,
  output logic                           SC_RANDOMGEN_busy_Out,
  output logic [1:0]                     SC_RANDOMGEN_state_dbg_o
);

  // Prescaler is at least one bit wide so PRESCALE=1 still elaborates.
  localparam int PW = (RANDOMGEN_PRESCALE > 1) ? $clog2(RANDOMGEN_PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(RANDOMGEN_PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  state_t                           state_q;
  logic [PW-1:0]                    presc_q;
  logic [RANDOMGEN_DATAWIDTH-1:0]   data_q;
  logic                             valid_q;
  logic                             busy_q;

  logic [RANDOMGEN_DATAWIDTH-1:0]   lfsr_next;
  logic [RANDOMGEN_DATAWIDTH-1:0]   seed_sel;
  logic                             seed_req;
  logic                             run_req;

  assign seed_req = ~SC_RANDOMGEN_seed_InLow;
  assign run_req  = ~SC_RANDOMGEN_run_InLow;

  // Galois step and zero-seed substitution; a zero value would lock the LFSR.
  always_comb begin
    lfsr_next = data_q >> 1;
    if (data_q[0]) begin
      lfsr_next = (data_q >> 1) ^ RANDOMGEN_TAPS;
    end
    seed_sel = SC_RANDOMGEN_seed_InBUS;
    if (SC_RANDOMGEN_seed_InBUS == '0) begin
      seed_sel = RANDOMGEN_SEED;
    end
  end

  // Control FSM with registered data, valid and busy outputs.
  // A seed request beats run in every state. Reset beats both.
  always_ff @(posedge SC_RANDOMGEN_CLOCK_50) begin
    if (SC_RANDOMGEN_RESET_InHigh) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      data_q  <= RANDOMGEN_SEED;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (seed_req) begin
      state_q <= ST_LOAD;
      presc_q <= '0;
      data_q  <= seed_sel;
      valid_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          presc_q <= '0;
          if (run_req) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!run_req) begin
            // Leaving RUN discards any partial prescale count.
            state_q <= ST_IDLE;
            presc_q <= '0;
            busy_q  <= 1'b0;
          end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            data_q  <= lfsr_next;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            presc_q <= presc_q + 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          presc_q <= '0;
          if (run_req) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          presc_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign SC_RANDOMGEN_data_OutBUS = data_q;
  assign SC_RANDOMGEN_valid_Out   = valid_q;
  assign SC_RANDOMGEN_busy_Out    = busy_q;
  assign SC_RANDOMGEN_state_dbg_o = state_q;

endmodule

// File: tb/tb_sc_randomgen.sv
// Bench for sc_randomgen: directed scenarios plus a random phase. A reference
// model predicts the outputs. The driver pushes each prediction into
// scoreboard queues. A monitor pops the queues and compares them after every
// clock edge.
module tb_sc_randomgen;

  localparam int         P    = 4;
  localparam logic [7:0] TAPS = 8'hB8;
  localparam logic [7:0] SEED = 8'hA5;

  logic       clk;
  logic       rst;
  logic       run_n;
  logic       seed_n;
  logic [7:0] seed_bus;
  logic [7:0] data_o;
  logic       valid_o;
  logic       busy_o;
  logic [1:0] state_dbg;

  sc_randomgen #(
    .RANDOMGEN_DATAWIDTH(8),
    .RANDOMGEN_TAPS     (TAPS),
    .RANDOMGEN_SEED     (SEED),
    .RANDOMGEN_PRESCALE (P)
  ) dut (
    .SC_RANDOMGEN_CLOCK_50    (clk),
    .SC_RANDOMGEN_RESET_InHigh(rst),
    .SC_RANDOMGEN_run_InLow   (run_n),
    .SC_RANDOMGEN_seed_InLow  (seed_n),
    .SC_RANDOMGEN_seed_InBUS  (seed_bus),
    .SC_RANDOMGEN_data_OutBUS (data_o),
    .SC_RANDOMGEN_valid_Out   (valid_o),
    .SC_RANDOMGEN_busy_Out    (busy_o),
    .SC_RANDOMGEN_state_dbg_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst      = 1'b1;
    run_n    = 1'b1;
    seed_n   = 1'b1;
    seed_bus = 8'h00;
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];   // data expected on each valid pulse
  logic [9:0] cyc_q[$];   // per-edge {busy, valid, data}
  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // The model tracks "running or not" and the number of edges spent running
  // since entry. A step is due whenever that count reaches a multiple of P.
  logic [7:0] m_data    = SEED;
  bit         m_running = 1'b0;
  int         m_edges   = 0;
  bit         m_valid   = 1'b0;

  function automatic logic [7:0] lfsr(input logic [7:0] v);
    if (v % 2 == 1) return (v / 2) ^ TAPS;
    return v / 2;
  endfunction

  task automatic model_edge(input logic r, input logic rn, input logic sn,
                            input logic [7:0] s);
    m_valid = 1'b0;
    if (r) begin
      m_data = SEED; m_running = 1'b0; m_edges = 0;
    end else if (!sn) begin
      m_data = (s == 8'h00) ? SEED : s;
      m_running = 1'b0; m_edges = 0; m_valid = 1'b1;
    end else if (!m_running) begin
      if (!rn) begin m_running = 1'b1; m_edges = 0; end
    end else if (rn) begin
      m_running = 1'b0; m_edges = 0;
    end else begin
      m_edges++;
      if (m_edges % P == 0) begin
        m_data = lfsr(m_data);
        m_valid = 1'b1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic r, input logic rn, input logic sn,
                       input logic [7:0] s);
    @(negedge clk);
    rst = r; run_n = rn; seed_n = sn; seed_bus = s;
    model_edge(r, rn, sn, s);
    cyc_q.push_back({m_running, m_valid, m_data});
    if (m_valid) exp_q.push_back(m_data);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  bit track_en = 1'b0;
  int seen[256];
  int track_cnt = 0;

  always @(posedge clk) begin
    logic [9:0] e;
    logic [7:0] d;
    #1;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      n_vec++;
      if (busy_o !== e[9] || valid_o !== e[8] || data_o !== e[7:0]) begin
        n_err++;
        $display("FAIL cycle t=%0t: got busy=%b valid=%b data=0x%0h, expected busy=%b valid=%b data=0x%0h",
                 $time, busy_o, valid_o, data_o, e[9], e[8], e[7:0]);
      end
      if (data_o == 8'h00) begin
        n_err++;
        $display("FAIL nonzero t=%0t: got data=0x00, expected nonzero", $time);
      end
    end
    if (valid_o === 1'b1) begin
      if (track_en) begin
        seen[data_o]++;
        track_cnt++;
      end
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL valid_pulse t=%0t: got unexpected pulse data=0x%0h, expected none", $time, data_o);
      end else begin
        d = exp_q.pop_front();
        if (data_o !== d) begin
          n_err++;
          $display("FAIL valid_data t=%0t: got 0x%0h, expected 0x%0h", $time, data_o, d);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int distinct;
    int r;
    logic rn_r;

    // Reset held for 2 edges.
    cycle(1, 1, 1, 8'h00);
    cycle(1, 1, 1, 8'h00);
    settle();
    chk("reset_data", data_o, 8'hA5);
    chk("reset_valid", valid_o, 0);
    chk("reset_busy", busy_o, 0);

    // Run from the first edge after reset: A5 -> EA -> 75 -> 82.
    repeat (13) cycle(0, 0, 1, 8'h00);
    settle();
    chk("run3_data", data_o, 8'h82);
    chk("run3_busy", busy_o, 1);

    // Seed 0x01 from IDLE, then run five steps ending at 0xB3.
    cycle(0, 1, 1, 8'h00);
    cycle(0, 1, 0, 8'h01);
    settle();
    chk("seed01_data", data_o, 8'h01);
    chk("seed01_valid", valid_o, 1);
    repeat (21) cycle(0, 0, 1, 8'h00);
    settle();
    chk("seed01_run5", data_o, 8'hB3);

    // A zero seed is replaced by the default seed.
    cycle(0, 1, 1, 8'h00);
    cycle(0, 1, 0, 8'h00);
    settle();
    chk("seed00_data", data_o, 8'hA5);

    // Partial count is discarded when run drops.
    cycle(0, 1, 1, 8'h00);
    cycle(0, 0, 1, 8'h00);
    repeat (2) cycle(0, 0, 1, 8'h00);
    repeat (3) cycle(0, 1, 1, 8'h00);
    settle();
    chk("pause_busy", busy_o, 0);
    chk("pause_data", data_o, 8'hA5);
    cycle(0, 0, 1, 8'h00);
    repeat (3) cycle(0, 0, 1, 8'h00);
    settle();
    chk("reentry_nostep", data_o, 8'hA5);
    cycle(0, 0, 1, 8'h00);
    settle();
    chk("reentry_step", data_o, 8'hEA);

    // Reset wins over a seed request during RUN.
    repeat (6) cycle(0, 0, 1, 8'h00);
    cycle(1, 0, 0, 8'h33);
    settle();
    chk("rst_seed_data", data_o, 8'hA5);
    chk("rst_seed_valid", valid_o, 0);
    chk("rst_seed_busy", busy_o, 0);

    // Full period: 255 steps from 0xA5, all distinct and nonzero.
    for (int i = 0; i < 256; i++) seen[i] = 0;
    track_cnt = 0;
    track_en = 1'b1;
    repeat (1 + 255 * P) cycle(0, 0, 1, 8'h00);
    settle();
    track_en = 1'b0;
    distinct = 0;
    for (int i = 0; i < 256; i++) if (seen[i] > 0) distinct++;
    chk("period_final", data_o, 8'hA5);
    chk("period_steps", track_cnt, 255);
    chk("period_distinct", distinct, 255);
    chk("period_zero", seen[0], 0);

    // Random mix of reset, seed and run with a sticky run level.
    rn_r = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 9) == 0) rn_r = ~rn_r;
      if (r < 2)
        cycle(1, rn_r, $urandom_range(0, 1), 8'($urandom_range(0, 255)));
      else if (r < 10)
        cycle(0, rn_r, 0, ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(0, 255)));
      else
        cycle(0, rn_r, 1, 8'($urandom_range(0, 255)));
    end
    cycle(0, 1, 1, 8'h00);
    settle();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("cyc_q_drained", cyc_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
